bitvault_host_ctrl: RTL and testbench
=====================================

// Module: bitvault_host_ctrl
// PURPOSE
//   Initiator-side controller for the BitVault register file: the master that drives its write port and reads its data port.
//   Accepts single read/write requests on a valid/ready handshake.
//   Sequences them onto BitVault's write_enable/address/data_in pins and captures data_out.
//   Returns one response per request on a valid/ready handshake.
//   Sits between a bus/CPU-side agent and one BitVault instance.
// PARAMETERS
//   ADDR_W  2  address width; DEPTH = 2**ADDR_W entries
//   DATA_W  8  data width
// PORTS
//   clk        in   1       single clock, all logic on rising edge
//   rst_n      in   1       asynchronous, active-low reset
//   req_valid  in   1       request present
//   req_ready  out  1       controller can accept a request (IDLE only)
//   req_write  in   1       1 = write, 0 = read
//   req_addr   in   ADDR_W  target entry
//   req_wdata  in   DATA_W  write data (ignored for reads)
//   rsp_valid  out  1       response present
//   rsp_ready  in   1       consumer accepts response
//   rsp_write  out  1       response belongs to a write (1) or read (0)
//   rsp_rdata  out  DATA_W  read data; echo of written data for writes
//   mem_we     out  1       to BitVault write_enable
//   mem_addr   out  ADDR_W  to BitVault address
//   mem_wdata  out  DATA_W  to BitVault data_in
//   mem_rdata  in   DATA_W  from BitVault data_out; registered, valid 1 cycle after address sampled
// BEHAVIOUR
//   Reset (async assert, sync release): FSM=IDLE, req_ready=1, rsp_valid=0, rsp_write=0, rsp_rdata=0, mem_we=0, mem_addr=0, mem_wdata=0.
//   Request accepted on an edge with req_valid & req_ready (call it edge N).
//     - req_addr and req_wdata are registered into mem_addr/mem_wdata at that edge.
//     - Both are held stable until the next accept.
//   FSM states: IDLE, WR, RD, RD_CAP, RESP (plus CLR, see CONFIGURATION).
//     - IDLE -> WR on write accept; IDLE -> RD on read accept.
//     - WR: mem_we=1 for exactly one cycle (N..N+1); then RESP with rsp_rdata=mem_wdata, rsp_write=1.
//     - RD: mem_we=0, address presented; then RD_CAP.
//     - RD_CAP: rsp_rdata <= mem_rdata at end of cycle; then RESP with rsp_write=0.
//     - RESP: rsp_valid=1; rsp_rdata/rsp_write stable until rsp_valid & rsp_ready; then IDLE.
//   Latency from accept edge N to rsp_valid: write = 2 cycles, read = 3 cycles.
//   Throughput with rsp_ready tied high: write every 3 cycles, read every 4.
//   req_ready is 1 only in IDLE. req_valid outside IDLE is ignored and does not stall the FSM.
//   mem_we is 0 in every state except WR (and CLR).
//   rsp_ready held low: stay in RESP indefinitely, no new request accepted.
//   rsp_ready high in the first RESP cycle: IDLE on the next edge.
//   Reset mid-operation: in-flight request dropped, no response.
//     - mem_we drops immediately.
//     - The BitVault entry being written has undefined contents.
// CONFIGURATION
//   Macro BITVAULT_HOST_CLEAR_EN.
//   Defined:
//     - Adds ports clr_start (in, 1) and clr_busy (out, 1, reset 0), and state CLR.
//     - In IDLE, clr_start=1 -> CLR, taking priority over req_valid in the same cycle; that request is not accepted.
//     - CLR: mem_we=1, mem_wdata=0; mem_addr counts 0..DEPTH-1, one entry per cycle (DEPTH cycles).
//     - After entry DEPTH-1 is written, return to IDLE; the counter does not wrap.
//     - clr_busy=1 and req_ready=0 throughout CLR; no response is generated.
//     - clr_start outside IDLE is ignored.
//   Undefined: no clr_* ports, no CLR state; all other behaviour identical.
// TESTING
//   Bench instantiates BitVault behind this block, clk period 20, rsp_ready=1 unless stated.
//   1 Write 0->10, 1->20, read 0, read 1
//     -> rsp_rdata 10 then 20, rsp_write=0.
//     -> write rsp_valid 2 cycles and read rsp_valid 3 cycles after accept.
//   2 Read addr 3 after writing 8'hA5, with rsp_ready low for 5 cycles
//     -> rsp_valid held, rsp_rdata=8'hA5 stable; IDLE/req_ready=1 the cycle after rsp_ready rises.
//   3 req_valid held high continuously with alternating requests
//     -> req_ready pulses once per transaction; no duplicate or lost responses.
//     -> mem_we high exactly 1 cycle per write.
//   4 Assert rst_n=0 during RD_CAP of a read
//     -> all outputs at reset values immediately; no response after release.
//     -> next write/read of addr 2 (value 7) works normally.
//   5 (CLEAR_EN) Fill 0..3 with 1..4, then clr_start and req_valid together
//     -> request refused; clr_busy=1 for 4 cycles, mem_addr 0,1,2,3.
//     -> subsequent reads all return 0.
//   6 Write addr 3 then addr 0 back-to-back
//     -> mem_addr wraps cleanly 3->0; reads return written values; other entries unchanged.

Source files
------------

// File: rtl/bitvault_host_ctrl.sv
// Initiator-side controller for a BitVault register file: one request in, one memory access, one response out.
// Optional bulk clear of every entry is built when BITVAULT_HOST_CLEAR_EN is defined.
module bitvault_host_ctrl #(
    parameter int ADDR_W = 2,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_write,
    output logic [DATA_W-1:0] rsp_rdata,
`ifdef BITVAULT_HOST_CLEAR_EN
    input  logic              clr_start,
    output logic              clr_busy,
`endif
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [2:0] {
        IDLE,
        WR,
        RD,
        RD_CAP,
        RESP
`ifdef BITVAULT_HOST_CLEAR_EN
        , CLR
`endif
    } state_t;

    state_t state, state_nxt;
    logic   accept;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        case (state)
            IDLE: begin
`ifdef BITVAULT_HOST_CLEAR_EN
                if (clr_start) state_nxt = CLR;
                else
`endif
                if (req_valid) begin
                    accept    = 1'b1;
                    state_nxt = req_write ? WR : RD;
                end
            end
            WR:     state_nxt = RESP;
            RD:     state_nxt = RD_CAP;
            RD_CAP: state_nxt = RESP;
            RESP:   if (rsp_ready) state_nxt = IDLE;
`ifdef BITVAULT_HOST_CLEAR_EN
            CLR:    if (mem_addr == '1) state_nxt = IDLE;
`endif
            default: state_nxt = IDLE;
        endcase
    end

    // Decoded straight from the state register so reset drops mem_we without waiting for an edge.
    always_comb begin
        req_ready = (state == IDLE);
        rsp_valid = (state == RESP);
        mem_we    = (state == WR);
`ifdef BITVAULT_HOST_CLEAR_EN
        req_ready = (state == IDLE) && !clr_start;
        mem_we    = (state == WR) || (state == CLR);
        clr_busy  = (state == CLR);
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_addr  <= '0;
            mem_wdata <= '0;
            rsp_rdata <= '0;
            rsp_write <= 1'b0;
        end else begin
            if (accept) begin
                mem_addr  <= req_addr;
                mem_wdata <= req_wdata;
            end
            case (state)
                WR: begin
                    rsp_rdata <= mem_wdata;
                    rsp_write <= 1'b1;
                end
                RD_CAP: begin
                    rsp_rdata <= mem_rdata;
                    rsp_write <= 1'b0;
                end
`ifdef BITVAULT_HOST_CLEAR_EN
                IDLE: if (state_nxt == CLR) begin
                    mem_addr  <= '0;
                    mem_wdata <= '0;
                end
                CLR: if (mem_addr != '1) mem_addr <= mem_addr + ADDR_W'(1);
`endif
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bitvault_host_ctrl.sv
// Directed bench for bitvault_host_ctrl with a behavioural BitVault (registered read port) behind it.
// Covers the clear sequence too when BITVAULT_HOST_CLEAR_EN is defined.
module tb_bitvault_host_ctrl;
    localparam int ADDR_W = 2;
    localparam int DATA_W = 8;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic              req_write = 1'b0;
    logic [ADDR_W-1:0] req_addr = '0;
    logic [DATA_W-1:0] req_wdata = '0;
    logic              rsp_valid;
    logic              rsp_ready = 1'b1;
    logic              rsp_write;
    logic [DATA_W-1:0] rsp_rdata;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
`ifdef BITVAULT_HOST_CLEAR_EN
    logic              clr_start = 1'b0;
    logic              clr_busy;
`endif

    bitvault_host_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_write (rsp_write),
        .rsp_rdata (rsp_rdata),
`ifdef BITVAULT_HOST_CLEAR_EN
        .clr_start (clr_start),
        .clr_busy  (clr_busy),
`endif
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    always #10 clk = ~clk;

    // BitVault: synchronous write, registered read of the presented address.
    logic [DATA_W-1:0] vault [4];
    always @(posedge clk) begin
        if (mem_we) vault[mem_addr] <= mem_wdata;
        mem_rdata <= vault[mem_addr];
    end

    int we_count = 0;
    always @(negedge clk) if (mem_we) we_count++;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_txn(input logic wr, input logic [1:0] addr, input logic [7:0] wdata,
                          input logic [7:0] exp);
        int lat;
        int we0;
        check("idle_ready", req_ready, 1);
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = addr;
        req_wdata = wdata;
        we0 = we_count;
        tick();
        req_valid = 1'b0;
        check("mem_addr_latched", mem_addr, addr);
        if (wr) check("mem_wdata_latched", mem_wdata, wdata);
        lat = 1;
        while (!rsp_valid && lat < 10) begin
            tick();
            lat++;
        end
        check(wr ? "wr_latency" : "rd_latency", lat, wr ? 2 : 3);
        check("rsp_write", rsp_write, wr);
        check("rsp_rdata", rsp_rdata, exp);
        tick();
        check("rsp_consumed", rsp_valid, 0);
        check("back_to_idle", req_ready, 1);
        check("we_cycles", we_count - we0, wr ? 1 : 0);
    endtask

    typedef struct {
        logic       wr;
        logic [1:0] addr;
        logic [7:0] wdata;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs[9];
    vec_t alt[4];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Writes/reads of entries 0 and 1, then 3 and 0 back-to-back (address wrap).
        vecs[0] = '{1'b1, 2'd0, 8'd10,  8'd10};
        vecs[1] = '{1'b1, 2'd1, 8'd20,  8'd20};
        vecs[2] = '{1'b0, 2'd0, 8'hFF,  8'd10};
        vecs[3] = '{1'b0, 2'd1, 8'hFF,  8'd20};
        vecs[4] = '{1'b1, 2'd3, 8'h33,  8'h33};
        vecs[5] = '{1'b1, 2'd0, 8'h44,  8'h44};
        vecs[6] = '{1'b0, 2'd3, 8'h00,  8'h33};
        vecs[7] = '{1'b0, 2'd0, 8'h00,  8'h44};
        vecs[8] = '{1'b0, 2'd1, 8'h00,  8'd20};
        alt[0]  = '{1'b1, 2'd1, 8'h5A,  8'h5A};
        alt[1]  = '{1'b0, 2'd1, 8'h00,  8'h5A};
        alt[2]  = '{1'b1, 2'd2, 8'h6B,  8'h6B};
        alt[3]  = '{1'b0, 2'd2, 8'h00,  8'h6B};

        // Reset values while held in reset.
        tick();
        tick();
        check("rst_req_ready", req_ready, 1);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_write", rsp_write, 0);
        check("rst_rsp_rdata", rsp_rdata, 0);
        check("rst_mem_we", mem_we, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 9; i++) do_txn(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].exp);

        // Response back-pressure: rsp_ready low for 5 cycles of RESP.
        begin
            int lat;
            do_txn(1'b1, 2'd3, 8'hA5, 8'hA5);
            rsp_ready = 1'b0;
            req_valid = 1'b1;
            req_write = 1'b0;
            req_addr  = 2'd3;
            tick();
            req_valid = 1'b0;
            lat = 1;
            while (!rsp_valid && lat < 10) begin
                tick();
                lat++;
            end
            check("hold_latency", lat, 3);
            req_valid = 1'b1;
            req_write = 1'b1;
            req_addr  = 2'd0;
            req_wdata = 8'hEE;
            for (int i = 0; i < 5; i++) begin
                check("hold_valid", rsp_valid, 1);
                check("hold_rdata", rsp_rdata, 8'hA5);
                check("hold_write", rsp_write, 0);
                check("hold_no_ready", req_ready, 0);
                tick();
            end
            req_valid = 1'b0;
            rsp_ready = 1'b1;
            tick();
            check("release_idle", req_ready, 1);
            check("release_no_rsp", rsp_valid, 0);
            do_txn(1'b0, 2'd0, 8'h00, 8'h44);
        end

        // req_valid held high across alternating write/read requests.
        begin
            int idx = 0;
            int pulses = 0;
            int cyc = 0;
            int we0;
            logic pend = 1'b0;
            logic [8:0] got[$];
            logic [8:0] g;
            we0 = we_count;
            req_valid = 1'b1;
            req_write = alt[0].wr;
            req_addr  = alt[0].addr;
            req_wdata = alt[0].wdata;
            while (got.size() < 4 && cyc < 60) begin
                if (req_valid && req_ready) begin
                    pulses++;
                    pend = 1'b1;
                end
                if (rsp_valid) got.push_back({rsp_write, rsp_rdata});
                tick();
                cyc++;
                if (pend) begin
                    pend = 1'b0;
                    idx++;
                    if (idx < 4) begin
                        req_write = alt[idx].wr;
                        req_addr  = alt[idx].addr;
                        req_wdata = alt[idx].wdata;
                    end else begin
                        req_valid = 1'b0;
                    end
                end
            end
            check("alt_rsp_count", got.size(), 4);
            check("alt_ready_pulses", pulses, 4);
            check("alt_we_cycles", we_count - we0, 2);
            for (int i = 0; i < 4; i++) begin
                g = (i < got.size()) ? got[i] : 9'h1FF;
                check("alt_rsp", g, {alt[i].wr, alt[i].exp});
            end
            for (int i = 0; i < 3; i++) begin
                tick();
                check("alt_no_extra_rsp", rsp_valid, 0);
            end
        end

        // Reset in the middle of a write (WR) and of a read (RD_CAP).
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = 2'd3;
        req_wdata = 8'hEE;
        tick();
        req_valid = 1'b0;
        check("pre_rst_we", mem_we, 1);
        rst_n = 1'b0;
        #1;
        check("rst_wr_mem_we", mem_we, 0);
        tick();
        rst_n = 1'b1;
        tick();
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = 2'd1;
        tick();
        req_valid = 1'b0;
        tick();
        rst_n = 1'b0;
        #1;
        check("rst_cap_req_ready", req_ready, 1);
        check("rst_cap_rsp_valid", rsp_valid, 0);
        check("rst_cap_rsp_rdata", rsp_rdata, 0);
        check("rst_cap_mem_we", mem_we, 0);
        check("rst_cap_mem_addr", mem_addr, 0);
        check("rst_cap_mem_wdata", mem_wdata, 0);
        tick();
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            check("rst_no_rsp", rsp_valid, 0);
        end
        do_txn(1'b1, 2'd2, 8'd7, 8'd7);
        do_txn(1'b0, 2'd2, 8'd0, 8'd7);

`ifdef BITVAULT_HOST_CLEAR_EN
        // Clear wins over a simultaneous request and zeroes every entry.
        for (int i = 0; i < 4; i++) do_txn(1'b1, 2'(i), 8'(i + 1), 8'(i + 1));
        clr_start = 1'b1;
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = 2'd1;
        req_wdata = 8'h99;
        #1;
        check("clr_refuse_ready", req_ready, 0);
        tick();
        clr_start = 1'b0;
        req_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("clr_busy", clr_busy, 1);
            check("clr_we", mem_we, 1);
            check("clr_addr", mem_addr, i);
            check("clr_wdata", mem_wdata, 0);
            check("clr_no_ready", req_ready, 0);
            check("clr_no_rsp", rsp_valid, 0);
            tick();
        end
        check("clr_done_busy", clr_busy, 0);
        check("clr_done_ready", req_ready, 1);
        for (int i = 0; i < 4; i++) do_txn(1'b0, 2'(i), 8'd0, 8'd0);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
